// File: rtl/tinyqv_mem_arbiter.sv
// Shares the byte-serial memory port between TinyQV instruction fetch and data loads/stores.
// Define TINYQV_MEM_ARB_POSTED_WRITE_EN to acknowledge stores early from an internal write buffer.
module tinyqv_mem_arbiter #(
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ADDR_BITS-2:0] instr_addr,
  input  logic                 instr_fetch_restart,
  input  logic                 instr_fetch_stall,
  output logic                 instr_fetch_started,
  output logic                 instr_fetch_stopped,
  output logic [7:0]           instr_data_out,
  output logic                 instr_ready,
  input  logic [ADDR_BITS:0]   data_addr,
  input  logic [1:0]           data_write_n,
  input  logic [1:0]           data_read_n,
  input  logic [31:0]          data_in,
  output logic [3:0]           data_ready,
  output logic [31:0]          data_out,
  output logic                 mem_start,
  output logic [ADDR_BITS:0]   mem_addr,
  output logic                 mem_write,
  output logic                 mem_stop,
  input  logic                 mem_busy,
  input  logic [7:0]           mem_byte_in,
  input  logic                 mem_byte_valid,
  output logic [7:0]           mem_byte_out,
  input  logic                 mem_byte_req
);

  typedef enum logic [2:0] {IDLE, FETCH, FETCH_STOP, DREAD, DWRITE, DSTOP} state_t;

  state_t state_q, state_d;

  logic                 mem_start_q, mem_start_d;
  logic [ADDR_BITS:0]   mem_addr_q, mem_addr_d;
  logic                 mem_write_q, mem_write_d;
  logic                 mem_stop_q, mem_stop_d;
  logic [7:0]           mem_byte_out_q, mem_byte_out_d;
  logic                 instr_fetch_started_q, instr_fetch_started_d;
  logic                 instr_fetch_stopped_q, instr_fetch_stopped_d;
  logic [7:0]           instr_data_out_q, instr_data_out_d;
  logic                 instr_ready_q, instr_ready_d;
  logic [3:0]           data_ready_q, data_ready_d;
  logic [31:0]          data_out_q, data_out_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [1:0]           len_q, len_d;
  logic [31:0]          wr_src;

`ifdef TINYQV_MEM_ARB_POSTED_WRITE_EN
  logic [31:0] wbuf_q, wbuf_d;
  logic        wr_ack_q, wr_ack_d;
  assign wr_src = wbuf_q;
`else
  assign wr_src = data_in;
`endif

  logic wr_req, data_req, fetch_go, fetch_exit, cnt_last;

  // Size code 00/01/10 maps to index of the last byte: 0/1/3.
  function automatic logic [1:0] last_idx(input logic [1:0] size_n);
    return {size_n[1], size_n[1] | size_n[0]};
  endfunction

  assign wr_req     = (data_write_n != 2'b11);
  assign data_req   = wr_req || (data_read_n != 2'b11);
  assign fetch_go   = instr_fetch_restart && !instr_fetch_stall;
  assign fetch_exit = instr_fetch_stall || !instr_fetch_restart || data_req;
  assign cnt_last   = (cnt_q == len_q);

  // NOTE: reset is synchronous here; every flop only changes on clk, and uses <= so all
  // registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: each comb block assigns a default to every output first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!mem_busy) begin
          if (data_req)      state_d = wr_req ? DWRITE : DREAD;
          else if (fetch_go) state_d = FETCH;
        end
      end
      FETCH:      if (fetch_exit) state_d = FETCH_STOP;
      FETCH_STOP: if (!mem_busy) state_d = IDLE;
      DREAD:      if (mem_byte_valid && cnt_last) state_d = DSTOP;
      DWRITE:     if (mem_byte_req && cnt_last) state_d = DSTOP;
      DSTOP:      if (!mem_busy) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_start_d           = 1'b0;
    mem_stop_d            = 1'b0;
    instr_fetch_started_d = 1'b0;
    instr_fetch_stopped_d = 1'b0;
    instr_ready_d         = 1'b0;
    data_ready_d          = 4'b0000;
    mem_addr_d            = mem_addr_q;
    mem_write_d           = mem_write_q;
    mem_byte_out_d        = mem_byte_out_q;
    instr_data_out_d      = instr_data_out_q;
    data_out_d            = data_out_q;
    cnt_d                 = cnt_q;
    len_d                 = len_q;
`ifdef TINYQV_MEM_ARB_POSTED_WRITE_EN
    wbuf_d   = wbuf_q;
    wr_ack_d = 1'b0;
    if (wr_ack_q) data_ready_d[0] = 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (!mem_busy && data_req) begin
          mem_start_d = 1'b1;
          mem_addr_d  = data_addr;
          mem_write_d = wr_req;
          len_d       = wr_req ? last_idx(data_write_n) : last_idx(data_read_n);
          cnt_d       = 2'd0;
          if (wr_req) mem_byte_out_d = data_in[7:0];
`ifdef TINYQV_MEM_ARB_POSTED_WRITE_EN
          if (wr_req) begin
            wbuf_d   = data_in;
            wr_ack_d = 1'b1;
          end
`endif
        end else if (!mem_busy && fetch_go) begin
          mem_start_d           = 1'b1;
          mem_addr_d            = {1'b0, instr_addr, 1'b0};
          mem_write_d           = 1'b0;
          instr_fetch_started_d = 1'b1;
        end
      end
      FETCH: begin
        if (mem_byte_valid) begin
          instr_data_out_d = mem_byte_in;
          instr_ready_d    = 1'b1;
        end
        if (fetch_exit) mem_stop_d = 1'b1;
      end
      FETCH_STOP: begin
        if (!mem_busy) instr_fetch_stopped_d = 1'b1;
      end
      DREAD: begin
        if (mem_byte_valid) begin
          data_out_d[{cnt_q, 3'b000} +: 8] = mem_byte_in;
          data_ready_d[cnt_q]              = 1'b1;
          cnt_d                            = cnt_q + 2'd1;
          if (cnt_last) mem_stop_d = 1'b1;
        end
      end
      DWRITE: begin
        if (mem_byte_req) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_last) mem_stop_d = 1'b1;
        end
        mem_byte_out_d = wr_src[{cnt_d, 3'b000} +: 8];
      end
      DSTOP: begin
`ifndef TINYQV_MEM_ARB_POSTED_WRITE_EN
        if (!mem_busy && mem_write_q) data_ready_d[0] = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_start_q           <= 1'b0;
      mem_addr_q            <= '0;
      mem_write_q           <= 1'b0;
      mem_stop_q            <= 1'b0;
      mem_byte_out_q        <= 8'h00;
      instr_fetch_started_q <= 1'b0;
      instr_fetch_stopped_q <= 1'b0;
      instr_data_out_q      <= 8'h00;
      instr_ready_q         <= 1'b0;
      data_ready_q          <= 4'b0000;
      data_out_q            <= 32'h0;
      cnt_q                 <= 2'd0;
      len_q                 <= 2'd0;
`ifdef TINYQV_MEM_ARB_POSTED_WRITE_EN
      wbuf_q                <= 32'h0;
      wr_ack_q              <= 1'b0;
`endif
    end else begin
      mem_start_q           <= mem_start_d;
      mem_addr_q            <= mem_addr_d;
      mem_write_q           <= mem_write_d;
      mem_stop_q            <= mem_stop_d;
      mem_byte_out_q        <= mem_byte_out_d;
      instr_fetch_started_q <= instr_fetch_started_d;
      instr_fetch_stopped_q <= instr_fetch_stopped_d;
      instr_data_out_q      <= instr_data_out_d;
      instr_ready_q         <= instr_ready_d;
      data_ready_q          <= data_ready_d;
      data_out_q            <= data_out_d;
      cnt_q                 <= cnt_d;
      len_q                 <= len_d;
`ifdef TINYQV_MEM_ARB_POSTED_WRITE_EN
      wbuf_q                <= wbuf_d;
      wr_ack_q              <= wr_ack_d;
`endif
    end
  end

  assign mem_start           = mem_start_q;
  assign mem_addr            = mem_addr_q;
  assign mem_write           = mem_write_q;
  assign mem_stop            = mem_stop_q;
  assign mem_byte_out        = mem_byte_out_q;
  assign instr_fetch_started = instr_fetch_started_q;
  assign instr_fetch_stopped = instr_fetch_stopped_q;
  assign instr_data_out      = instr_data_out_q;
  assign instr_ready         = instr_ready_q;
  assign data_ready          = data_ready_q;
  assign data_out            = data_out_q;

endmodule

// File: tb/tb_tinyqv_mem_arbiter.sv
// Self-checking bench for tinyqv_mem_arbiter: scripted memory engine plus a scoreboard
// of expected fetch/load bytes popped as instr_ready / data_ready pulses appear.
module tb_tinyqv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [22:0] instr_addr = '0;
  logic        instr_fetch_restart = 1'b0;
  logic        instr_fetch_stall = 1'b0;
  logic        instr_fetch_started, instr_fetch_stopped, instr_ready;
  logic [7:0]  instr_data_out;
  logic [24:0] data_addr = '0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_in = '0;
  logic [3:0]  data_ready;
  logic [31:0] data_out;
  logic        mem_start, mem_write, mem_stop;
  logic [24:0] mem_addr;
  logic        mem_busy = 1'b0;
  logic [7:0]  mem_byte_in = '0;
  logic        mem_byte_valid = 1'b0;
  logic [7:0]  mem_byte_out;
  logic        mem_byte_req = 1'b0;

  tinyqv_mem_arbiter #(.ADDR_BITS(24)) dut (
    .clk(clk), .rstn(rstn),
    .instr_addr(instr_addr), .instr_fetch_restart(instr_fetch_restart),
    .instr_fetch_stall(instr_fetch_stall), .instr_fetch_started(instr_fetch_started),
    .instr_fetch_stopped(instr_fetch_stopped), .instr_data_out(instr_data_out),
    .instr_ready(instr_ready), .data_addr(data_addr), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_in(data_in), .data_ready(data_ready),
    .data_out(data_out), .mem_start(mem_start), .mem_addr(mem_addr),
    .mem_write(mem_write), .mem_stop(mem_stop), .mem_busy(mem_busy),
    .mem_byte_in(mem_byte_in), .mem_byte_valid(mem_byte_valid),
    .mem_byte_out(mem_byte_out), .mem_byte_req(mem_byte_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_data;
    logic [1:0] idx;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_load = 1'b0;
  int   n_started = 0;
  int   n_stopped = 0;

  // Scoreboard: every delivered byte must match the oldest expected one.
  task automatic sb();
    exp_t e;
    if (instr_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL sb_instr unexpected instr_ready byte=%h", instr_data_out);
      end else begin
        e = exp_q.pop_front();
        if (e.is_data || instr_data_out !== e.val) begin
          failures++; $display("FAIL sb_instr got=%h exp=%h (exp_is_data=%0d)", instr_data_out, e.val, e.is_data);
        end
      end
    end
    if (mon_load && data_ready !== 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL sb_data unexpected data_ready=%b", data_ready);
      end else begin
        e = exp_q.pop_front();
        if (!e.is_data || data_ready !== (4'b0001 << e.idx) || data_out[{e.idx, 3'b000} +: 8] !== e.val) begin
          failures++;
          $display("FAIL sb_data strobe=%b exp=%b byte=%h exp=%h", data_ready, 4'b0001 << e.idx,
                   data_out[{e.idx, 3'b000} +: 8], e.val);
        end
      end
    end
    if (instr_fetch_started === 1'b1) n_started++;
    if (instr_fetch_stopped === 1'b1) n_stopped++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sb();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    checks++;
    if ({mem_start, mem_stop, mem_write, instr_fetch_started, instr_fetch_stopped, instr_ready, data_ready} !== 10'b0) begin
      failures++; $display("FAIL reset_pulses got=%b exp=0", {mem_start, mem_stop, mem_write, instr_fetch_started, instr_fetch_stopped, instr_ready, data_ready});
    end
    checks++;
    if (mem_addr !== 25'h0 || data_out !== 32'h0 || instr_data_out !== 8'h0 || mem_byte_out !== 8'h0) begin
      failures++; $display("FAIL reset_data addr=%h dout=%h idout=%h mbo=%h exp=0", mem_addr, data_out, instr_data_out, mem_byte_out);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    logic [7:0] bytes [4];
    bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD;
    instr_addr = 23'h000100;
    instr_fetch_restart = 1'b1;
    tick();
    checks++;
    if (mem_start !== 1'b1 || mem_addr !== 25'h0000200 || mem_write !== 1'b0 || instr_fetch_started !== 1'b1) begin
      failures++; $display("FAIL fetch_start start=%b addr=%h wr=%b started=%b exp 1/0000200/0/1", mem_start, mem_addr, mem_write, instr_fetch_started);
    end
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_byte_in = bytes[i];
      mem_byte_valid = 1'b1;
      exp_q.push_back('{is_data: 1'b0, idx: 2'd0, val: bytes[i]});
      tick();
      if (i == 0) begin
        checks++;
        if (mem_start !== 1'b0 || instr_fetch_started !== 1'b0) begin
          failures++; $display("FAIL fetch_pulse_width start=%b started=%b exp 0/0", mem_start, instr_fetch_started);
        end
      end
    end
    mem_byte_valid = 1'b0;
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL fetch_bytes pending=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    int base;
    base = n_stopped;
    instr_fetch_stall = 1'b1;
    tick();
    checks++;
    if (mem_stop !== 1'b1) begin
      failures++; $display("FAIL stall_stop mem_stop=%b exp=1", mem_stop);
    end
    mem_byte_in = 8'hEE;
    mem_byte_valid = 1'b1;
    tick();
    mem_byte_valid = 1'b0;
    checks++;
    if (mem_stop !== 1'b0 || instr_ready !== 1'b0 || instr_fetch_stopped !== 1'b0) begin
      failures++; $display("FAIL stall_discard stop=%b ready=%b stopped=%b exp 0/0/0", mem_stop, instr_ready, instr_fetch_stopped);
    end
    mem_busy = 1'b0;
    tick();
    checks++;
    if (instr_fetch_stopped !== 1'b1) begin
      failures++; $display("FAIL stall_stopped stopped=%b exp=1", instr_fetch_stopped);
    end
    tick(); tick();
    checks++;
    if (n_stopped - base != 1 || mem_start !== 1'b0) begin
      failures++; $display("FAIL stall_once stopped_pulses=%0d exp=1 start=%b exp=0", n_stopped - base, mem_start);
    end
  endtask

  task automatic test_load_preempt();
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    instr_fetch_stall = 1'b0;
    instr_fetch_restart = 1'b1;
    instr_addr = 23'h000200;
    tick();
    mem_busy = 1'b1;
    tick();
    data_read_n = 2'b10;
    data_addr = 25'h1000040;
    tick();
    checks++;
    if (mem_stop !== 1'b1 || mem_start !== 1'b0) begin
      failures++; $display("FAIL preempt_stop stop=%b start=%b exp 1/0", mem_stop, mem_start);
    end
    instr_fetch_restart = 1'b0;
    mem_busy = 1'b0;
    tick();
    checks++;
    if (instr_fetch_stopped !== 1'b1 || mem_start !== 1'b0) begin
      failures++; $display("FAIL preempt_idle stopped=%b start=%b exp 1/0", instr_fetch_stopped, mem_start);
    end
    tick();
    checks++;
    if (mem_start !== 1'b1 || mem_addr !== 25'h1000040 || mem_write !== 1'b0) begin
      failures++; $display("FAIL load_start start=%b addr=%h wr=%b exp 1/1000040/0", mem_start, mem_addr, mem_write);
    end
    data_read_n = 2'b11;
    data_addr = 25'h0;
    mem_busy = 1'b1;
    mon_load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_byte_in = bytes[i];
      mem_byte_valid = 1'b1;
      exp_q.push_back('{is_data: 1'b1, idx: 2'(i), val: bytes[i]});
      tick();
      mem_byte_valid = 1'b0;
      if (i < 3) tick();
    end
    checks++;
    if (mem_stop !== 1'b1 || data_out !== 32'h44332211) begin
      failures++; $display("FAIL load_done stop=%b data_out=%h exp 1/44332211", mem_stop, data_out);
    end
    mem_busy = 1'b0;
    tick();
    checks++;
    if (data_ready !== 4'b0000 || mem_stop !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL load_end ready=%b stop=%b pending=%0d exp 0/0/0", data_ready, mem_stop, exp_q.size());
    end
    mon_load = 1'b0;
    tick();
  endtask

  task automatic test_store();
    int early, late;
    early = 0; late = 0;
    data_addr = 25'h1000080;
    data_in = 32'hCAFEBEEF;
    data_write_n = 2'b01;
    tick();
    checks++;
    if (mem_start !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 25'h1000080 || mem_byte_out !== 8'hEF || data_ready !== 4'b0) begin
      failures++; $display("FAIL store_start start=%b wr=%b addr=%h byte=%h ready=%b exp 1/1/1000080/EF/0", mem_start, mem_write, mem_addr, mem_byte_out, data_ready);
    end
    data_write_n = 2'b11;
    mem_busy = 1'b1;
    mem_byte_req = 1'b1;
    tick();
    mem_byte_req = 1'b0;
    early += int'(data_ready[0]);
    checks++;
    if (mem_byte_out !== 8'hBE || mem_stop !== 1'b0) begin
      failures++; $display("FAIL store_byte1 byte=%h stop=%b exp BE/0", mem_byte_out, mem_stop);
    end
    tick();
    early += int'(data_ready[0]);
    mem_byte_req = 1'b1;
    tick();
    mem_byte_req = 1'b0;
    early += int'(data_ready[0]);
    checks++;
    if (mem_stop !== 1'b1) begin
      failures++; $display("FAIL store_stop mem_stop=%b exp=1", mem_stop);
    end
    tick();
    early += int'(data_ready[0]);
    mem_busy = 1'b0;
    tick();
    late += int'(data_ready[0]);
    tick();
    late += int'(data_ready[0]);
    checks++;
`ifdef TINYQV_MEM_ARB_POSTED_WRITE_EN
    if (early != 1 || late != 0) begin
      failures++; $display("FAIL store_ack early=%0d late=%0d exp 1/0", early, late);
    end
`else
    if (early != 0 || late != 1) begin
      failures++; $display("FAIL store_ack early=%0d late=%0d exp 0/1", early, late);
    end
`endif
  endtask

  task automatic test_same_cycle();
    int base;
    base = n_started;
    instr_addr = 23'h000010;
    instr_fetch_restart = 1'b1;
    data_read_n = 2'b00;
    data_addr = 25'h0000123;
    tick();
    checks++;
    if (mem_start !== 1'b1 || mem_addr !== 25'h0000123 || instr_fetch_started !== 1'b0) begin
      failures++; $display("FAIL same_cycle_data start=%b addr=%h started=%b exp 1/0000123/0", mem_start, mem_addr, instr_fetch_started);
    end
    data_read_n = 2'b11;
    mem_busy = 1'b1;
    mon_load = 1'b1;
    mem_byte_in = 8'h5A;
    mem_byte_valid = 1'b1;
    exp_q.push_back('{is_data: 1'b1, idx: 2'd0, val: 8'h5A});
    tick();
    mem_byte_valid = 1'b0;
    checks++;
    if (mem_stop !== 1'b1) begin
      failures++; $display("FAIL same_cycle_stop mem_stop=%b exp=1", mem_stop);
    end
    mem_busy = 1'b0;
    tick();
    tick();
    checks++;
    if (instr_fetch_started !== 1'b1 || mem_addr !== 25'h0000020 || n_started - base != 1) begin
      failures++; $display("FAIL same_cycle_fetch started=%b addr=%h pulses=%0d exp 1/0000020/1", instr_fetch_started, mem_addr, n_started - base);
    end
    checks++;
    if (data_out !== 32'h4433225A) begin
      failures++; $display("FAIL same_cycle_dout data_out=%h exp=4433225a", data_out);
    end
    mon_load = 1'b0;
    instr_fetch_restart = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_read();
    data_read_n = 2'b10;
    data_addr = 25'h0000400;
    tick();
    data_read_n = 2'b11;
    mem_busy = 1'b1;
    mon_load = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_byte_in = 8'(i + 1);
      mem_byte_valid = 1'b1;
      exp_q.push_back('{is_data: 1'b1, idx: 2'(i), val: 8'(i + 1)});
      tick();
      mem_byte_valid = 1'b0;
    end
    rstn = 1'b0;
    tick();
    checks++;
    if ({mem_start, mem_stop, mem_write, instr_fetch_started, instr_fetch_stopped, instr_ready, data_ready} !== 10'b0) begin
      failures++; $display("FAIL midreset_pulses got=%b exp=0", {mem_start, mem_stop, mem_write, instr_fetch_started, instr_fetch_stopped, instr_ready, data_ready});
    end
    checks++;
    if (mem_addr !== 25'h0 || data_out !== 32'h0 || instr_data_out !== 8'h0 || mem_byte_out !== 8'h0) begin
      failures++; $display("FAIL midreset_data addr=%h dout=%h idout=%h mbo=%h exp=0", mem_addr, data_out, instr_data_out, mem_byte_out);
    end
    rstn = 1'b1;
    mem_busy = 1'b0;
    mon_load = 1'b0;
    tick();
    instr_addr = 23'h000080;
    instr_fetch_restart = 1'b1;
    tick();
    checks++;
    if (mem_start !== 1'b1 || mem_addr !== 25'h0000100 || instr_fetch_started !== 1'b1) begin
      failures++; $display("FAIL midreset_fetch start=%b addr=%h started=%b exp 1/0000100/1", mem_start, mem_addr, instr_fetch_started);
    end
    mem_busy = 1'b1;
    mem_byte_in = 8'h77;
    mem_byte_valid = 1'b1;
    exp_q.push_back('{is_data: 1'b0, idx: 2'd0, val: 8'h77});
    tick();
    mem_byte_valid = 1'b0;
    instr_fetch_restart = 1'b0;
    tick();
    mem_busy = 1'b0;
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain pending=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_load_preempt();
    test_store();
    test_same_cycle();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
